lsu_mem_master: RTL and testbench

- Load/store initiator between the core datapath and the word-organised data memory, which has combinational read, synchronous write and byte lanes.
- Accepts one byte/half/word request per handshake and computes byte enables and lane shifts.
- Splits accesses that cross a word boundary into two word accesses.
- Returns aligned, sign- or zero-extended load data or a store acknowledge through a valid/ready response channel.

---
 rtl/lsu_mem_master.sv | 192 +++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-organised, byte-laned data memory.
// Handles byte/half/word accesses, splits word-crossing accesses in two, and extends load data.
module lsu_mem_master #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r;
  logic        we_r;
  logic        uns_r;
  logic        split_r;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic [3:0]  be_hi_r;
  logic [31:0] wdata_hi_r;
  logic [31:0] lo_r;

  logic [2:0]  nbytes_s;
  logic [3:0]  mask_s;
  logic [7:0]  lanes_s;
  logic [63:0] wshift_s;
  logic [32:0] last_byte_s;
  logic        split_s;
  logic        err_s;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] off, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] both;
    logic [31:0] raw;
    both = {hi, lo} >> {off, 3'b000};
    raw  = both[31:0];
    case (size)
      2'b00:   return uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Decode the incoming request: lane masks for both words, shifted write data, range check.
  // Upper halves of lanes_s/wshift_s are exactly the second-word enables and data of a split.
  always_comb begin
    nbytes_s    = size_bytes(req_size);
    mask_s      = size_mask(req_size);
    lanes_s     = {4'b0000, mask_s} << req_addr[1:0];
    wshift_s    = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
    last_byte_s = {1'b0, req_addr} + {30'd0, nbytes_s} - 33'd1;
    split_s     = ({2'b00, req_addr[1:0]} + {1'b0, nbytes_s}) > 4'd4;
    err_s       = (req_size == 2'b11) || (last_byte_s >= 33'(ADDR_LIMIT));
  end

  assign req_ready = (state_r == IDLE) && !rst;

  // Access sequencer with registered memory strobes and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      split_r    <= 1'b0;
      off_r      <= 2'b00;
      size_r     <= 2'b00;
      be_hi_r    <= 4'b0000;
      wdata_hi_r <= 32'h0000_0000;
      lo_r       <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_r       <= req_we;
            uns_r      <= req_unsigned;
            split_r    <= split_s;
            off_r      <= req_addr[1:0];
            size_r     <= req_size;
            be_hi_r    <= lanes_s[7:4];
            wdata_hi_r <= wshift_s[63:32];
            if (err_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else begin
              state_r   <= ACC0;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_we    <= req_we;
              mem_be    <= lanes_s[3:0];
              mem_wdata <= wshift_s[31:0];
            end
          end
        end
        ACC0: begin
          lo_r <= mem_rdata;
          if (split_r) begin
            state_r   <= ACC1;
            mem_addr  <= mem_addr + 32'd4;
            mem_we    <= we_r;
            mem_be    <= be_hi_r;
            mem_wdata <= wdata_hi_r;
          end else begin
            state_r    <= RESP;
            mem_addr   <= 32'h0000_0000;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0000_0000;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_r ? 32'h0000_0000
                               : load_extend(32'h0000_0000, mem_rdata, off_r, size_r, uns_r);
          end
        end
        ACC1: begin
          state_r    <= RESP;
          mem_addr   <= 32'h0000_0000;
          mem_we     <= 1'b0;
          mem_be     <= 4'b0000;
          mem_wdata  <= 32'h0000_0000;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_r ? 32'h0000_0000
                             : load_extend(mem_rdata, lo_r, off_r, size_r, uns_r);
        end
        RESP: begin
          if (resp_ready) begin
            state_r    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
          end
        end
        default: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          mem_addr   <= 32'h0000_0000;
          mem_we     <= 1'b0;
          mem_be     <= 4'b0000;
          mem_wdata  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-addressed reference memory model, directed test-plan steps and random traffic.
module tb_lsu_mem_master;
  localparam int unsigned LIMIT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;

  bit [31:0] tb_mem [LIMIT/4];
  bit [7:0]  ref_mem [LIMIT];
  int n_pass = 0;
  int n_total = 0;

  lsu_mem_master #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Data memory: combinational read, byte-laned synchronous write.
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_we)
      tb_mem[mem_addr[9:2]] <= (tb_mem[mem_addr[9:2]] & ~lane_mask(mem_be)) | (mem_wdata & lane_mask(mem_be));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int n;
    n = nbytes_of(size);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[addr + i]} << (8 * i));
    if (n == 1) v = (uns || !v[7]) ? v : (v | 32'hFFFF_FF00);
    if (n == 2) v = (uns || !v[15]) ? v : (v | 32'hFFFF_0000);
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int stall,
                        output logic [31:0] rdata);
    int n, exp_n, n_rec, cycles, lat;
    logic err;
    logic [63:0] last;
    logic [31:0] a, w, exp_rdata;
    logic [31:0] exp_waddr [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    logic [31:0] rec_addr [4];
    logic [3:0]  rec_be [4];
    logic        rec_we [4];
    logic [31:0] rec_wd [4];
    n = nbytes_of(size);
    last = {32'd0, addr} + 64'(n) - 64'd1;
    err = (size == 2'b11) || (last >= 64'(LIMIT));
    exp_n = 0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        w = a & 32'hFFFF_FFFC;
        if (exp_n == 0 || exp_waddr[exp_n-1] != w) begin
          exp_waddr[exp_n] = w;
          exp_be[exp_n] = 4'd0;
          exp_wd[exp_n] = 32'd0;
          exp_n++;
        end
        exp_be[exp_n-1][a[1:0]] = 1'b1;
        exp_wd[exp_n-1][8*a[1:0] +: 8] = wdata[8*i +: 8];
      end
    end
    lat = err ? 1 : ((exp_n == 2) ? 3 : 2);
    exp_rdata = (we || err) ? 32'd0 : ref_load(addr, size, uns);

    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cycles = 1;
    n_rec = 0;
    while (!resp_valid && cycles < 8) begin
      if (mem_be != 4'd0 || mem_we) begin
        if (n_rec < 4) begin
          rec_addr[n_rec] = mem_addr; rec_be[n_rec] = mem_be;
          rec_we[n_rec] = mem_we; rec_wd[n_rec] = mem_wdata;
        end
        n_rec++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    chk("resp_latency", cycles, lat);
    chk("access_count", n_rec, exp_n);
    for (int i = 0; i < exp_n && i < n_rec; i++) begin
      chk("acc_addr", rec_addr[i], exp_waddr[i]);
      chk("acc_be", {28'd0, rec_be[i]}, {28'd0, exp_be[i]});
      chk("acc_we", rec_we[i], we);
      if (we) chk("acc_wdata", rec_wd[i] & lane_mask(rec_be[i]), exp_wd[i]);
    end
    chk("resp_err", resp_err, err);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("mem_idle_in_resp", (mem_we || mem_be != 4'd0 || mem_addr != 32'd0 || mem_wdata != 32'd0), 1'b0);
    rdata = resp_rdata;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, rdata);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_dropped", resp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    if (we && !err)
      for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r_addr;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_idle", (mem_we || mem_be != 4'd0 || mem_addr != 32'd0 || mem_wdata != 32'd0), 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd);
    chk("lw_0x10", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h13, 32'h000000A5, 2'b00, 1'b0, 0, rd);
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd);
    chk("lb_0x13", rd, 32'hFFFFFFA5);
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd);
    chk("lbu_0x13", rd, 32'h000000A5);
    do_req(1'b1, 32'h07, 32'h00001234, 2'b01, 1'b0, 0, rd);
    do_req(1'b0, 32'h07, 32'h0, 2'b01, 1'b0, 0, rd);
    chk("lh_0x07", rd, 32'h00001234);
    do_req(1'b1, 32'h20, 32'h33221100, 2'b10, 1'b0, 0, rd);
    do_req(1'b1, 32'h24, 32'h77665544, 2'b10, 1'b0, 0, rd);
    do_req(1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 0, rd);
    chk("lw_0x22", rd, 32'h55443322);

    do_req(1'b0, 32'h3FE, 32'h0, 2'b10, 1'b0, 0, rd);
    do_req(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 0, rd);
    do_req(1'b1, 32'h3FF, 32'hBEEF, 2'b01, 1'b0, 0, rd);
    do_req(1'b0, 32'hFFFF_FFFE, 32'h0, 2'b10, 1'b0, 0, rd);
    do_req(1'b1, 32'h3FC, 32'h0BADF00D, 2'b10, 1'b0, 0, rd);
    do_req(1'b0, 32'h3FF, 32'h0, 2'b00, 1'b1, 0, rd);
    do_req(1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 5, rd);

    for (int t = 0; t < 200; t++) begin
      r_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1100)) : 32'($urandom_range(0, 1023));
      do_req(1'($urandom_range(0, 1)), r_addr, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), rd);
    end

    // Reset in the middle of a split store: only the first word is written.
    req_we = 1'b1; req_addr = 32'h31; req_wdata = 32'hCAFEF00D; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("split_acc0_addr", mem_addr, 32'h30);
    @(posedge clk); #1;
    chk("split_acc1_addr", mem_addr, 32'h34);
    rst = 1'b1;
    #1;
    chk("midrst_mem_idle", (mem_we || mem_be != 4'd0 || mem_addr != 32'd0 || mem_wdata != 32'd0), 1'b0);
    chk("midrst_resp", {30'd0, resp_valid, resp_err} | resp_rdata, 32'd0);
    chk("midrst_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    ref_mem[32'h31] = 8'h0D; ref_mem[32'h32] = 8'hF0; ref_mem[32'h33] = 8'hFE;
    do_req(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 0, rd);
    do_req(1'b0, 32'h34, 32'h0, 2'b10, 1'b0, 0, rd);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
